inst_fetch_unit: RTL and testbench

//  Instruction-fetch front end feeding the decode/control path.
//  - Holds the PC and fetches one word per instruction over a req/ack handshake to instruction memory.
//  - Latches the word into an instruction register and presents its decoded fields (op, func, rs, rt, rd, imm) to the decoder.
//  - Computes the next PC from the decoder's Branch and the ALU zero flag; a taken branch redirects the PC.

---
 rtl/inst_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//   Instruction-fetch front end for the MIPS-subset core. It holds the PC and
//   fetches one word per instruction over a req/ack handshake. The word is
//   latched into the IR, and the IR's decoded fields are presented to the
//   decoder. When the core consumes the instruction, the unit computes the
//   next PC from the decoder's branch and the ALU zero flag.
//
// Handshakes:
//   imem side : imem_req stays high with a stable imem_addr until imem_ack.
//               imem_rdata is captured in the cycle where imem_ack=1. An ack
//               that arrives while no request is pending is ignored.
//   core side : inst_valid stays high with stable fields until inst_ready.
//               A transfer happens on a rising edge with
//               inst_valid & inst_ready. branch/zero are sampled only on that
//               edge. inst_ready without inst_valid is ignored.
//
// Configuration macro:
//   INST_FETCH_JUMP_EN - when defined, a j instruction (op=000010) in the IR
//                        redirects the PC to {pc_plus4[31:28], target, 2'b00}.
//                        This takes priority over branch.
//
// Ports:
//   clk, rst_n              clock (rising edge); async active-low reset
//   imem_req, imem_addr     fetch request and word-aligned address
//   imem_ack, imem_rdata    memory response
//   inst_valid, inst_ready  IR-holds-instruction / core-consumes handshake
//   branch, zero            next-PC control for the current instruction
//   op, rs, rt, rd,
//   func, imm               decoded IR fields
//   pc_out, pc_plus4        address of the IR instruction and that address + 4
//   dbg_state               current FSM state (0=FETCH, 1=VALID)
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              branch,
    input  logic              zero,
    output logic [5:0]        op,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        func,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              dbg_state
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_VALID = 1'b1
    } state_t;

`ifdef INST_FETCH_JUMP_EN
    localparam logic [5:0] OP_J = 6'b000010;
`endif

    state_t            state;
    logic [ADDR_W-1:0] pc;       // address being fetched / to fetch next
    logic [ADDR_W-1:0] ir_pc;    // address of the instruction held in the IR
    logic [31:0]       ir;
    logic              req_q;
    logic              valid_q;
    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] next_pc;

    // ir_pc is a separate register so that pc_out keeps describing the IR
    // contents during FETCH. During that state, pc has already moved on.
    assign pc_plus4   = ir_pc + ADDR_W'(4);
    assign branch_off = {{14{ir[15]}}, ir[15:0], 2'b00};

    always_comb begin
        if (branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end else begin
            next_pc = pc_plus4;
        end
`ifdef INST_FETCH_JUMP_EN
        if (ir[31:26] == OP_J) begin
            next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir_pc   <= RESET_PC;
            ir      <= 32'h0;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir      <= imem_rdata;
                        ir_pc   <= pc;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state   <= S_VALID;
                    end
                end
                S_VALID: begin
                    // An ack that arrives here has no request behind it,
                    // so it is ignored.
                    if (inst_ready) begin
                        pc      <= next_pc;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        state   <= S_FETCH;
                    end
                end
                default: begin
                    state   <= S_FETCH;
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc;
    assign inst_valid = valid_q;
    assign op         = ir[31:26];
    assign rs         = ir[25:21];
    assign rt         = ir[20:16];
    assign rd         = ir[15:11];
    assign func       = ir[5:0];
    assign imm        = ir[15:0];
    assign pc_out     = ir_pc;
    assign dbg_state  = state;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance (RESET_PC = 0)
  logic        imem_req, imem_ack, inst_valid, inst_ready, branch, zero, dbg_state;
  logic [31:0] imem_addr, imem_rdata, pc_out, pc_plus4;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  // wrap instance (RESET_PC = 0xFFFFFFFC)
  logic        w_req, w_ack, w_valid, w_ready, w_branch, w_zero, w_dbg;
  logic [31:0] w_addr, w_rdata, w_pc_out, w_pc4;
  logic [5:0]  w_op, w_func;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm;

  inst_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .branch(branch), .zero(zero),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .func(func), .imm(imm),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .dbg_state(dbg_state)
  );

  inst_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .inst_valid(w_valid), .inst_ready(w_ready), .branch(w_branch), .zero(w_zero),
    .op(w_op), .rs(w_rs), .rt(w_rt), .rd(w_rd), .func(w_func), .imm(w_imm),
    .pc_out(w_pc_out), .pc_plus4(w_pc4), .dbg_state(w_dbg)
  );

`ifdef INST_FETCH_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;   // model PC of the next fetch

  // Reference rule for the address fetched after an instruction at pc.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
                                             input logic br, input logic zr);
    logic [31:0] seq;
    int off;
    seq = pc + 32'd4;
    if (JUMP_EN && word[31:26] == 6'd2) return {seq[31:28], word[25:0], 2'b00};
    if (br && zr) begin
      off = int'($signed(word[15:0])) * 4;
      return seq + 32'(off);
    end
    return seq;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0; branch = 1'b0; zero = 1'b0;
    w_ack = 1'b0; w_rdata = '0; w_ready = 1'b0; w_branch = 1'b0; w_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_pc = 32'h0;
  endtask

  // One full instruction on the main instance. The task waits ack_dly cycles
  // in FETCH, acks with word, then waits rdy_dly cycles in VALID and consumes
  // the word with the given branch and zero values. It records what it sees.
  task automatic run_instr(input logic [31:0] word, input int ack_dly, input int rdy_dly,
                           input logic br, input logic zr,
                           output logic [31:0] o_addr, output logic o_wait_ok,
                           output logic o_valid, output logic [31:0] o_word,
                           output logic [31:0] o_pc, output logic [31:0] o_pc4,
                           output logic o_hold_ok, output logic [31:0] o_next_addr,
                           output logic o_next_req, output logic o_next_valid);
    o_addr = imem_addr;
    o_wait_ok = imem_req && !inst_valid;
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack = 1'b0; imem_rdata = $urandom;
      inst_ready = 1'($urandom_range(0, 1));   // must be ignored while fetching
      @(posedge clk); #1;
      if (!(imem_req && !inst_valid && imem_addr == o_addr)) o_wait_ok = 1'b0;
    end
    inst_ready = 1'b0; imem_ack = 1'b1; imem_rdata = word;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    o_valid = inst_valid;
    o_word = {op, rs, rt, rd, imm[10:6], func};
    o_pc = pc_out;
    o_pc4 = pc_plus4;
    o_hold_ok = !imem_req && (imm[15:11] == rd) && (imm[5:0] == func);
    for (int i = 0; i < rdy_dly; i++) begin
      imem_ack = 1'($urandom_range(0, 1));     // stray acks must be ignored
      imem_rdata = $urandom;
      branch = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (!(inst_valid && !imem_req && {op, rs, rt, rd, imm[10:6], func} == o_word && pc_out == o_pc))
        o_hold_ok = 1'b0;
    end
    imem_ack = 1'b0; inst_ready = 1'b1; branch = br; zero = zr;
    @(posedge clk); #1;
    inst_ready = 1'b0; branch = 1'b0; zero = 1'b0;
    o_next_addr = imem_addr;
    o_next_req = imem_req;
    o_next_valid = inst_valid;
  endtask

  // observation variables shared by the scenario tasks (used sequentially)
  logic [31:0] o_addr, o_word, o_pc, o_pc4, o_next;
  logic o_wait_ok, o_valid, o_hold_ok, o_nreq, o_nvalid;

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=00000000", imem_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    total++; if ({op, rs, rt, imm} !== 32'h0) begin bad++; $display("FAIL reset_ir got=%h exp=00000000", {op, rs, rt, imm}); end
    total++; if (w_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL reset_w_addr got=%h exp=fffffffc", w_addr); end
  endtask

  task automatic test_basic();
    run_instr(32'h0085_1020, 0, 0, 1'b0, 1'b0, o_addr, o_wait_ok, o_valid, o_word, o_pc, o_pc4,
              o_hold_ok, o_next, o_nreq, o_nvalid);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", o_valid); end
    total++; if (op !== 6'd0 || rs !== 5'd4 || rt !== 5'd5 || rd !== 5'd2 || func !== 6'h20)
      begin bad++; $display("FAIL basic_fields got=%h/%0d/%0d/%0d/%h exp=0/4/5/2/20", op, rs, rt, rd, func); end
    total++; if (o_pc !== 32'h0 || o_pc4 !== 32'h4) begin bad++; $display("FAIL basic_pc got=%h,%h exp=0,4", o_pc, o_pc4); end
    total++; if (o_next !== 32'h4 || o_nreq !== 1'b1 || o_nvalid !== 1'b0)
      begin bad++; $display("FAIL basic_next got=%h req=%b v=%b exp=4 req=1 v=0", o_next, o_nreq, o_nvalid); end
    // in FETCH the fields still describe the last IR contents
    total++; if (func !== 6'h20 || pc_out !== 32'h0) begin bad++; $display("FAIL basic_hold_fetch got=%h,%h exp=20,0", func, pc_out); end
    m_pc = 32'h4;
  endtask

  task automatic test_branch();
    run_instr(32'h0, 1, 0, 1'b1, 1'b1, o_addr, o_wait_ok, o_valid, o_word, o_pc, o_pc4,
              o_hold_ok, o_next, o_nreq, o_nvalid);   // nop: op=0, imm=0 -> branch target = +4
    total++; if (o_next !== 32'h8) begin bad++; $display("FAIL br_nop got=%h exp=00000008", o_next); end
    run_instr(32'h1085_FFFF, 0, 2, 1'b1, 1'b1, o_addr, o_wait_ok, o_valid, o_word, o_pc, o_pc4,
              o_hold_ok, o_next, o_nreq, o_nvalid);
    total++; if (o_addr !== 32'h8 || o_pc !== 32'h8) begin bad++; $display("FAIL br_at got=%h,%h exp=8,8", o_addr, o_pc); end
    total++; if (o_next !== 32'h8) begin bad++; $display("FAIL br_taken got=%h exp=00000008", o_next); end
    total++; if (!o_hold_ok) begin bad++; $display("FAIL br_hold got=%b exp=1", o_hold_ok); end
    run_instr(32'h1085_FFFF, 0, 0, 1'b1, 1'b0, o_addr, o_wait_ok, o_valid, o_word, o_pc, o_pc4,
              o_hold_ok, o_next, o_nreq, o_nvalid);
    total++; if (o_next !== 32'hC) begin bad++; $display("FAIL br_not_taken got=%h exp=0000000c", o_next); end
    m_pc = 32'hC;
  endtask

  task automatic test_wrap();
    // dut_w has sat in FETCH at 0xFFFFFFFC since reset release
    total++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req got=%b,%h exp=1,fffffffc", w_req, w_addr); end
    w_ack = 1'b1; w_rdata = 32'h0;
    @(posedge clk); #1;
    w_ack = 1'b0;
    total++; if (w_valid !== 1'b1 || w_pc_out !== 32'hFFFF_FFFC || w_pc4 !== 32'h0)
      begin bad++; $display("FAIL wrap_pc got=%b,%h,%h exp=1,fffffffc,0", w_valid, w_pc_out, w_pc4); end
    w_ready = 1'b1;
    @(posedge clk); #1;
    w_ready = 1'b0;
    total++; if (w_addr !== 32'h0 || w_req !== 1'b1) begin bad++; $display("FAIL wrap_addr got=%h,%b exp=0,1", w_addr, w_req); end
  endtask

  task automatic test_jump();
    logic [31:0] exp;
    do_reset();
    exp = JUMP_EN ? 32'h40 : 32'h4;
    run_instr(32'h0800_0010, 0, 1, 1'b0, 1'b0, o_addr, o_wait_ok, o_valid, o_word, o_pc, o_pc4,
              o_hold_ok, o_next, o_nreq, o_nvalid);
    total++; if (o_next !== exp) begin bad++; $display("FAIL jump got=%h exp=%h", o_next, exp); end
    m_pc = exp;
  endtask

  task automatic test_random();
    logic [31:0] word, exp;
    logic [5:0] rop;
    logic br, zr;
    int ad, rdl;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: rop = 6'd0;
        1: rop = 6'd4;
        2: rop = 6'd2;
        default: rop = 6'($urandom);
      endcase
      word = {rop, 26'($urandom)};
      br = 1'($urandom_range(0, 1)); zr = 1'($urandom_range(0, 1));
      ad = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
      exp_q.push_back(model_next(m_pc, word, br, zr));
      run_instr(word, ad, rdl, br, zr, o_addr, o_wait_ok, o_valid, o_word, o_pc, o_pc4,
                o_hold_ok, o_next, o_nreq, o_nvalid);
      total++; if (o_addr !== m_pc || !o_wait_ok) begin bad++; $display("FAIL rnd_fetch n=%0d got=%h ok=%b exp=%h", n, o_addr, o_wait_ok, m_pc); end
      total++; if (o_valid !== 1'b1 || o_word !== word) begin bad++; $display("FAIL rnd_ir n=%0d got=%h v=%b exp=%h", n, o_word, o_valid, word); end
      total++; if (o_pc !== m_pc || o_pc4 !== m_pc + 32'd4) begin bad++; $display("FAIL rnd_pc n=%0d got=%h,%h exp=%h", n, o_pc, o_pc4, m_pc); end
      total++; if (!o_hold_ok) begin bad++; $display("FAIL rnd_hold n=%0d got=0 exp=1", n); end
      exp = exp_q.pop_front();
      total++; if (o_next !== exp || o_nreq !== 1'b1 || o_nvalid !== 1'b0)
        begin bad++; $display("FAIL rnd_next n=%0d got=%h req=%b v=%b exp=%h", n, o_next, o_nreq, o_nvalid, exp); end
      m_pc = exp;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++)
      run_instr(32'h0, 0, 0, 1'b0, 1'b0, o_addr, o_wait_ok, o_valid, o_word, o_pc, o_pc4,
                o_hold_ok, o_next, o_nreq, o_nvalid);
    total++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin bad++; $display("FAIL mid_pre got=%h,%b exp=10,1", imem_addr, imem_req); end
    @(posedge clk); #1;           // still waiting for the ack
    rst_n = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    total++; if (imem_addr !== 32'h0 || inst_valid !== 1'b0) begin bad++; $display("FAIL mid_async got=%h,%b exp=0,0", imem_addr, inst_valid); end
    @(posedge clk); #1;           // the ack lands while reset is held
    imem_ack = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || inst_valid !== 1'b0 || {op, rs, rt, imm} !== 32'h0)
      begin bad++; $display("FAIL mid_release got=%h,%b,%b,%h exp=0,1,0,0", imem_addr, imem_req, inst_valid, {op, rs, rt, imm}); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_wrap();
    test_basic();
    test_branch();
    test_jump();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop against a stuck run
  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
